// File: rtl/fsub_arbiter.sv
// Round-robin issue controller sharing one pipelined fsub among N requesters.
// A tag pipeline matched to the fsub latency routes each result back to its issuer.
module fsub_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_x1,
  input  logic [32*N-1:0] req_x2,
  output logic [31:0]     fsub_x1,
  output logic [31:0]     fsub_x2,
  input  logic [31:0]     fsub_y,
  output logic [N-1:0]    resp_valid,
  output logic [31:0]     resp_y,
  output logic            busy
);

  localparam int PW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic               xfer;
  int                 cand;
  logic [LATENCY-1:0] tag_v;
  logic [PW-1:0]      tag_idx [LATENCY];

  // First valid requester after the last winner, searched in wrap-around order.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    xfer      = 1'b0;
    fsub_x1   = '0;
    fsub_x2   = '0;
    cand      = 0;
    if (en && !rst) begin
      for (int k = 1; k <= N; k++) begin
        cand = (int'(ptr) + k) % N;
        if (!xfer && req_valid[cand]) begin
          xfer            = 1'b1;
          gidx            = PW'(cand);
          req_ready[cand] = 1'b1;
          fsub_x1         = req_x1[32*cand +: 32];
          fsub_x2         = req_x2[32*cand +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= PW'(N-1);
      tag_v      <= '0;
      for (int k = 0; k < LATENCY; k++) tag_idx[k] <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
    end else begin
      if (xfer) ptr <= gidx;
      tag_v[0]   <= xfer;
      tag_idx[0] <= gidx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
      // Result strobe is a single cycle; requesters must capture it then.
      resp_valid <= tag_v[LATENCY-1] ? (ONE << tag_idx[LATENCY-1]) : '0;
      if (tag_v[LATENCY-1]) resp_y <= fsub_y;
    end
  end

  assign busy = (|tag_v) | (|resp_valid);

endmodule

// File: tb/tb_fsub_arbiter.sv
// Directed bench for fsub_arbiter with a 2-cycle stub subtractor and an
// expected-strobe table indexed by cycle number.
module tb_fsub_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_x1, req_x2;
  logic [31:0]     fsub_x1, fsub_x2, fsub_y;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_y;
  logic            busy;

  logic [31:0] opX1 [N];
  logic [31:0] opX2 [N];
  logic [31:0] stubS1, stubS2;
  logic [31:0] firstY;
  logic [N-1:0] expValid [256];
  logic [31:0]  expY [256];
  logic [31:0]  streamX1 [6];

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;

  fsub_arbiter #(.N(N), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2),
    .fsub_x1(fsub_x1), .fsub_x2(fsub_x2), .fsub_y(fsub_y),
    .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_x1[32*g +: 32] = opX1[g];
    assign req_x2[32*g +: 32] = opX2[g];
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in subtractor: known float pairs from a hand table, integer difference otherwise.
  function automatic logic [31:0] stubSub(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40400000, 32'h3F800000}: return 32'h40000000;
      {32'h3F800000, 32'h3F000000}: return 32'h3F000000;
      {32'h40000000, 32'h3F000000}: return 32'h3FC00000;
      {32'h40400000, 32'h3F000000}: return 32'h40200000;
      {32'h40800000, 32'h3F000000}: return 32'h40600000;
      {32'h40A00000, 32'h3F000000}: return 32'h40900000;
      {32'h40C00000, 32'h3F000000}: return 32'h40B00000;
      default:                      return a - b;
    endcase
  endfunction

  always @(posedge clk) begin
    stubS1 <= stubSub(fsub_x1, fsub_x2);
    stubS2 <= stubS1;
  end
  assign fsub_y = stubS2;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every non-reset cycle, the response strobe must match the table exactly.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("resp_valid", 32'(resp_valid), 32'(expValid[cyc]));
      if (expValid[cyc] != '0) checkOutput("resp_y", resp_y, expY[cyc]);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic enVal,
                               input logic [N-1:0] expGrant);
    int idx;
    idx       = 0;
    req_valid = valid;
    en        = enVal;
    #3;
    checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
    for (int i = 0; i < N; i++) if (expGrant[i]) idx = i;
    if (expGrant != '0) begin
      checkOutput("fsub_x1", fsub_x1, opX1[idx]);
      checkOutput("fsub_x2", fsub_x2, opX2[idx]);
      expValid[cyc+3] = expGrant;
      expY[cyc+3]     = stubSub(opX1[idx], opX2[idx]);
    end else begin
      checkOutput("fsub_x1_idle", fsub_x1, 32'h0);
      checkOutput("fsub_x2_idle", fsub_x2, 32'h0);
    end
  endtask

  task automatic clearFuture();
    for (int i = cyc; i < 256; i++) expValid[i] = '0;
  endtask

  task automatic bumpOps(input int idx);
    opX1[idx] = opX1[idx] + 32'h0001_0000;
    opX2[idx] = opX2[idx] + 32'h1;
  endtask

  task automatic doReset();
    nextCycle();
    rst       = 1'b1;
    req_valid = '0;
    clearFuture();
    nextCycle();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      applyStimulus('0, 1'b1, '0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      expValid[i] = '0;
      expY[i]     = '0;
    end
    for (int i = 0; i < N; i++) begin
      opX1[i] = {8'(i + 1), 24'h0};
      opX2[i] = 32'(i * 16);
    end
    streamX1 = '{32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40A00000, 32'h40C00000};

    // Reset held with every requester asking: nothing may leak out.
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #3;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_fsub_x1", fsub_x1, 32'h0);
    checkOutput("rst_fsub_x2", fsub_x2, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_y", resp_y, 32'h0);
    nextCycle();
    rst       = 1'b0;
    req_valid = '0;

    // Single op from requester 1: 3.0 - 1.0 = 2.0, strobe three cycles later.
    nextCycle();
    opX1[1] = 32'h40400000;
    opX2[1] = 32'h3F800000;
    applyStimulus(4'b0010, 1'b1, 4'b0010);
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      applyStimulus('0, 1'b1, '0);
      checkOutput("busy_single", 32'(busy), (k <= 3) ? 32'h1 : 32'h0);
    end
    checkOutput("resp_y_hold", resp_y, 32'h40000000);

    // Round-robin fairness with all four requesters valid.
    doReset();
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      if (c > 0) bumpOps((c - 1) % 4);
      applyStimulus(4'hF, 1'b1, 4'b0001 << (c % 4));
    end
    drain(4);

    // Requester 2 streams k+1.0 - 0.5 back-to-back.
    doReset();
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      opX1[2] = streamX1[k];
      opX2[2] = 32'h3F000000;
      applyStimulus(4'b0100, 1'b1, 4'b0100);
    end
    drain(4);

    // Enable low for three cycles; in-flight op still responds, issue resumes at ptr+1.
    doReset();
    nextCycle();
    applyStimulus(4'hF, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      if (k == 0) bumpOps(0);
      applyStimulus(4'hF, 1'b0, '0);
    end
    nextCycle();
    applyStimulus(4'hF, 1'b1, 4'b0010);
    nextCycle();
    bumpOps(1);
    applyStimulus('0, 1'b1, '0);
    drain(4);

    // Requester 0 regranted in the same cycle its first response strobes.
    doReset();
    nextCycle();
    applyStimulus(4'b0001, 1'b1, 4'b0001);
    firstY = stubSub(opX1[0], opX2[0]);
    nextCycle();
    bumpOps(0);
    applyStimulus('0, 1'b1, '0);
    nextCycle();
    applyStimulus('0, 1'b1, '0);
    nextCycle();
    applyStimulus(4'b0001, 1'b1, 4'b0001);
    nextCycle();
    applyStimulus('0, 1'b1, '0);
    checkOutput("resp_y_keep", resp_y, firstY);
    drain(4);

    // Asynchronous reset with two ops in flight: both must vanish.
    doReset();
    nextCycle();
    applyStimulus(4'b0001, 1'b1, 4'b0001);
    nextCycle();
    applyStimulus(4'b0010, 1'b1, 4'b0010);
    nextCycle();
    req_valid = '1;
    en        = 1'b1;
    #1;
    rst = 1'b1;
    clearFuture();
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("midrst_fsub_x1", fsub_x1, 32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 4'b0001);
    nextCycle();
    bumpOps(0);
    applyStimulus('0, 1'b1, '0);
    drain(4);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
